// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver
// Loop-back monitor for a multiplexed 4-digit 7-segment display bus.
// Synchronizes the scanned digit enables and segment lines, accepts a digit
// once its pattern has been steady for STABLE_CYCLES samples, decodes the
// segments back to hex, and presents complete 4-digit frames on a
// valid/ready handshake.
// Optional build macro: SEGRX_TIMEOUT_EN enables the scan watchdog that
// raises scan_timeout and drops a partial frame when scanning stalls.
module seg_scan_receiver #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          DIG_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [3:0]  seg_dig,
   input  logic [7:0]  seg_in,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  bad_digit,
   output logic        overrun,
   output logic        scan_timeout
);

   // Catch out-of-range configurations at elaboration time.
   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
      $error("seg_scan_receiver: STABLE_CYCLES must be 1..255");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("seg_scan_receiver: TIMEOUT_CYCLES must be 1..65535");
   end

   localparam logic [7:0] STABLE_MAX = STABLE_CYCLES[7:0];

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   // Synchronizer and sample-history flops
   logic [3:0]  dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
   logic [7:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [11:0] prev_q, prev_d;
   logic [7:0]  stab_q, stab_d;

   // Per-digit slots collected for the frame in progress
   logic [15:0] slot_code_q, slot_code_d;
   logic [3:0]  slot_dp_q, slot_dp_d;
   logic [3:0]  slot_bad_q, slot_bad_d;
   logic [3:0]  filled_q, filled_d;

   // Presented frame
   logic [15:0] digits_q, digits_d;
   logic [3:0]  dp_q, dp_d;
   logic [3:0]  bad_q, bad_d;
   logic        overrun_q, overrun_d;
   state_t      state_q, state_d;

   logic [3:0]  dig_n;
   logic [7:0]  seg_n;
   logic        dig_onehot;
   logic        same_sample;
   logic        capture;
   logic [4:0]  dec;
   logic        frame_done;
   logic        load_frame;
   logic        timeout_hit;

   // Map a gfedcba pattern to {bad, code}; unknown patterns decode as bad 0.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h3F:          r = 5'h00;
         7'h06:          r = 5'h01;
         7'h5B:          r = 5'h02;
         7'h4F:          r = 5'h03;
         7'h66:          r = 5'h04;
         7'h6D:          r = 5'h05;
         7'h7D:          r = 5'h06;
         7'h07, 7'h27:   r = 5'h07;
         7'h7F:          r = 5'h08;
         7'h6F, 7'h67:   r = 5'h09;
         7'h77:          r = 5'h0A;
         7'h7C:          r = 5'h0B;
         7'h39:          r = 5'h0C;
         7'h5E:          r = 5'h0D;
         7'h79:          r = 5'h0E;
         7'h71:          r = 5'h0F;
         default:        r = 5'h10;
      endcase
      return r;
   endfunction

   assign dig_n       = dig_s2_q ^ {4{DIG_ACTIVE_LOW}};
   assign seg_n       = seg_s2_q ^ {8{SEG_ACTIVE_LOW}};
   assign dig_onehot  = $onehot(dig_n);
   assign same_sample = ({dig_n, seg_n} == prev_q);
   assign dec         = decode_seg(seg_n[6:0]);
   assign frame_done  = (filled_q == 4'hF);

   // Synchronize the bus and qualify samples: capture once per stable run.
   always_comb begin
      dig_s1_d = seg_dig;
      dig_s2_d = dig_s1_q;
      seg_s1_d = seg_in;
      seg_s2_d = seg_s1_q;
      prev_d   = {dig_n, seg_n};
      stab_d   = 8'd0;
      capture  = 1'b0;
      if (dig_onehot) begin
         if (same_sample && (stab_q != 8'd0)) begin
            stab_d = (stab_q >= STABLE_MAX) ? STABLE_MAX : stab_q + 8'd1;
         end else begin
            stab_d = 8'd1;
         end
         // Fire only on the transition into the stable count, not while saturated.
         capture = (stab_d == STABLE_MAX) && !(same_sample && (stab_q == STABLE_MAX));
      end
   end

   // Write the active digit's slot on capture and track which slots are filled.
   always_comb begin
      slot_code_d = slot_code_q;
      slot_dp_d   = slot_dp_q;
      slot_bad_d  = slot_bad_q;
      filled_d    = (frame_done || timeout_hit) ? 4'h0 : filled_q;
      for (int i = 0; i < 4; i++) begin
         if (capture && dig_n[i]) begin
            slot_code_d[i*4 +: 4] = dec[3:0];
            slot_dp_d[i]          = seg_n[7];
            slot_bad_d[i]         = dec[4];
            filled_d[i]           = 1'b1;
         end
      end
   end

`ifdef SEGRX_TIMEOUT_EN
   localparam logic [15:0] WDOG_LIMIT = TIMEOUT_CYCLES[15:0];

   logic [15:0] wdog_q, wdog_d;
   logic        scan_timeout_q, scan_timeout_d;

   // Count cycles since the last capture; flag and drop the partial frame at the limit.
   always_comb begin
      wdog_d         = wdog_q;
      scan_timeout_d = scan_timeout_q;
      timeout_hit    = 1'b0;
      if (capture) begin
         wdog_d         = 16'd0;
         scan_timeout_d = 1'b0;
      end else begin
         if (wdog_q != 16'hFFFF) begin
            wdog_d = wdog_q + 16'd1;
         end
         if ((wdog_d == WDOG_LIMIT) && (wdog_q != WDOG_LIMIT)) begin
            timeout_hit    = 1'b1;
            scan_timeout_d = 1'b1;
         end
      end
   end

   // Watchdog registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wdog_q         <= 16'd0;
         scan_timeout_q <= 1'b0;
      end else begin
         wdog_q         <= wdog_d;
         scan_timeout_q <= scan_timeout_d;
      end
   end

   assign scan_timeout = scan_timeout_q;
`else
   assign timeout_hit  = 1'b0;
   assign scan_timeout = 1'b0;
`endif

   // Frame FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame FSM next state: stay presenting while back-to-back frames are accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: if (frame_done) state_d = ST_PRESENT;
         ST_PRESENT: if (frame_ready && !frame_done) state_d = ST_COLLECT;
         default:    state_d = ST_COLLECT;
      endcase
   end

   // Frame FSM outputs: load a finished frame unless the old one is still unread.
   always_comb begin
      load_frame  = frame_done && ((state_q == ST_COLLECT) || frame_ready);
      overrun_d   = overrun_q | (frame_done && (state_q == ST_PRESENT) && !frame_ready);
      digits_d    = load_frame ? slot_code_q : digits_q;
      dp_d        = load_frame ? slot_dp_q   : dp_q;
      bad_d       = load_frame ? slot_bad_q  : bad_q;
      frame_valid = (state_q == ST_PRESENT);
   end

   // Datapath registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         dig_s1_q    <= 4'h0;
         dig_s2_q    <= 4'h0;
         seg_s1_q    <= 8'h00;
         seg_s2_q    <= 8'h00;
         prev_q      <= 12'h000;
         stab_q      <= 8'd0;
         slot_code_q <= 16'h0000;
         slot_dp_q   <= 4'h0;
         slot_bad_q  <= 4'h0;
         filled_q    <= 4'h0;
         digits_q    <= 16'h0000;
         dp_q        <= 4'h0;
         bad_q       <= 4'h0;
         overrun_q   <= 1'b0;
      end else begin
         dig_s1_q    <= dig_s1_d;
         dig_s2_q    <= dig_s2_d;
         seg_s1_q    <= seg_s1_d;
         seg_s2_q    <= seg_s2_d;
         prev_q      <= prev_d;
         stab_q      <= stab_d;
         slot_code_q <= slot_code_d;
         slot_dp_q   <= slot_dp_d;
         slot_bad_q  <= slot_bad_d;
         filled_q    <= filled_d;
         digits_q    <= digits_d;
         dp_q        <= dp_d;
         bad_q       <= bad_d;
         overrun_q   <= overrun_d;
      end
   end

   assign digits    = digits_q;
   assign dp        = dp_q;
   assign bad_digit = bad_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/seg_scan_receiver.md
Name: seg_scan_receiver

Overview:
- Receiving end of the multiplexed 4-digit 7-segment display bus that the display selector drives: digit enables plus shared segment lines.
- Samples the scanned lines, waits for each digit pattern to settle, and decodes segments back to 4-bit hex codes.
- Assembles all four digits into a frame and presents it with a valid/ready handshake.
- Sits beside the display selector as a loop-back monitor, so the firmware side and the bench can read what the irrigation panel actually shows (counter digits, level, mix/clean indicators).

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples needed to accept a digit (range 1..255).
- DIG_ACTIVE_LOW, 1: digit enables are active-low when 1.
- SEG_ACTIVE_LOW, 1: segment lines are active-low when 1.
- TIMEOUT_CYCLES, 65535: scan watchdog limit. Used only with SEGRX_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- seg_dig  in  4  digit enables; bit0=D1 … bit3=D4.
- seg_in  in  8  segments {P,G,F,E,D,C,B,A}.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  frame available.
- digits  out  16  decoded codes; [3:0]=D1 … [15:12]=D4.
- dp  out  4  decimal point per digit.
- bad_digit  out  4  per-digit undecodable-pattern flag.
- overrun  out  1  sticky; a completed frame was dropped.
- scan_timeout  out  1  watchdog flag (0 when feature absent).

Behaviour:
- Reset (Rst=1 at a Clk edge): all outputs 0; slot-filled mask 0; stability counter 0; sync flops 0; FSM to COLLECT.
- Input path:
  - Two-flop synchronizer on seg_dig and seg_in.
  - Polarity normalized per parameters to active-high, giving dig_n and seg_n.
- Sample qualification:
  - A sample counts only if dig_n is one-hot. Zero or multiple enables clear the stability counter.
  - Counter increments while {dig_n, seg_n} equals the previous cycle's sample. It resets to 1 on any change and saturates at STABLE_CYCLES.
  - On the cycle the counter reaches STABLE_CYCLES, the slot for the active digit is written once: code, dp = seg_n[7], bad flag. Its filled bit is set.
  - Further stable cycles on the same digit do not rewrite the slot.
  - A slot already filled in the current frame is overwritten with the newer value. This is not an error.
- Decode of seg_n[6:0] (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 6 also accepts 7C? No: 7C maps to b. 7 also accepts 27. 9 also accepts 67.
  - Any other pattern, including blank 00: code 0, bad=1.
- FSM states:
  - COLLECT: when all four filled bits are set, copy slots to the holding registers, clear the mask, and go to PRESENT. frame_valid rises on the following cycle (capture-to-valid latency 1).
  - PRESENT: frame_valid=1; digits/dp/bad_digit held stable. Collection into the slots continues in parallel.
    - frame_ready=1 → frame_valid drops on the next edge, go to COLLECT.
    - A second frame completing while frame_valid=1 and frame_ready=0: discard it, set overrun, hold the old frame, clear the mask.
    - Completion on the same cycle as acceptance: load the new frame; frame_valid stays 1; no overrun.
- overrun is cleared only by Rst.
- Total latency from a stable pin pattern to slot capture: 2 + STABLE_CYCLES cycles.
- Rst asserted mid-frame discards partial slots and any pending frame.

Optional Feature:
- Macro SEGRX_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles since the last accepted digit capture and saturates.
  - When it reaches TIMEOUT_CYCLES: scan_timeout=1, the filled mask clears, and the FSM stays in its current state.
  - scan_timeout clears on the next accepted capture.
- Not defined: no counter; scan_timeout tied to 0.

Test Plan:
- Reset:
  - Stimulus: hold Rst 3 cycles with random inputs.
  - Required: all outputs 0; frame_valid stays 0 for 20 cycles with idle inputs (seg_dig=4'hF).
- Clean frame:
  - Stimulus: active-low scan, 8 cycles per digit, D1..D4 showing 1,2,A,0 (seg_in=~06,~5B,~77,~3F), dp on D2, frame_ready=0.
  - Required: frame_valid=1 with digits=16'h0A21, dp=4'b0010, bad_digit=0.
- Glitch rejection:
  - Stimulus: D3 pattern held only 3 cycles (STABLE_CYCLES=4), then correct for 8.
  - Required: only the 8-cycle value is captured; two simultaneous enables never cause a capture.
- Bad pattern:
  - Stimulus: blank on D4 (seg_in=8'hFF).
  - Required: digits[15:12]=0, bad_digit=4'b1000.
- Backpressure:
  - Stimulus: frame_ready=0 across two full scans.
  - Required: first frame held unchanged; overrun=1.
  - Then: pulse frame_ready → frame_valid=0 on the next edge; a third scan is presented normally.
- Timeout (SEGRX_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: capture D1 and D2, then hold seg_dig=4'hF.
  - Required: scan_timeout=1 at cycle 100 after the last capture; a subsequent D3+D4 alone does not produce a frame.
